cc_mim_sequencer: RTL and testbench
===================================

Name: cc_mim_sequencer

Overview:
- Microprogram sequencer (microPC + next-address logic) that drives the 11-bit address of the combinational 41-bit control store.
- Each cycle it takes the returned microword, evaluates COND against the datapath flags and the IR, and selects the next microaddress: increment, jump or decode.
- Stalls execution on memory microwords (RD/WR) until the memory handshake completes. Supports start, idle and halt.

Parameters:
- DATAWIDTH_UWORD, 41, control store word width.
- DATAWIDTH_UADDR, 11, microaddress width.
- DATAWIDTH_IR, 32, instruction register width.
- RESET_UADDR, 0, microaddress loaded at reset and on start.
- HALT_UADDR, 2047, microaddress whose execution ends the run.

Ports:
- CC_MIM_Sequencer_CLOCK_50  in  1  system clock, rising edge.
- CC_MIM_Sequencer_RESET_InLow  in  1  asynchronous active-low reset.
- CC_MIM_Sequencer_start_InLow  in  1  active-low start request (level, sampled each clock).
- CC_MIM_Sequencer_uword_InBUS  in  41  microword from the control store.
- CC_MIM_Sequencer_ir_InBUS  in  32  current instruction register.
- CC_MIM_Sequencer_flags_InBUS  in  4  {n,z,v,c} from the PSR.
- CC_MIM_Sequencer_memAck_In  in  1  memory completion, 1-cycle pulse.
- CC_MIM_Sequencer_uaddr_OutBUS  out  11  registered microPC to the control store.
- CC_MIM_Sequencer_exec_Out  out  1  datapath may commit the current microword this cycle.
- CC_MIM_Sequencer_memReq_Out  out  1  memory request, held until ack.
- CC_MIM_Sequencer_memWr_Out  out  1  1 = write, 0 = read; valid with memReq.
- CC_MIM_Sequencer_halted_Out  out  1  run finished.

Behaviour:
- Microword fields (MSB to LSB):
  - A[40:35], AMUX[34], B[33:28], BMUX[27], C[26:21], CMUX[20], RD[19], WR[18], ALU[17:14], COND[13:11], JADDR[10:0].
- Reset (async, active-low):
  - state = IDLE, uaddr = RESET_UADDR.
  - exec, memReq, memWr, halted all 0.
- FSM states: IDLE, RUN, WAIT_MEM, HALT.
- IDLE:
  - exec = 0.
  - start low → RUN next cycle, uaddr = RESET_UADDR.
- RUN, memory microword (RD or WR = 1):
  - memReq = 1 and memWr = WR, combinationally in the same cycle.
  - If memAck is high this cycle, exec = 1 and advance. Otherwise exec = 0, go to WAIT_MEM, hold uaddr.
  - RD = WR = 1 is treated as a write.
- RUN, no RD/WR: exec = 1, advance every cycle (1 microword/cycle).
- WAIT_MEM:
  - memReq stays 1 and uaddr is held.
  - On memAck: exec = 1 that cycle, advance, return to RUN.
- Advance (next uaddr by COND):
  - 000: uaddr+1.
  - 001/010/011/100: JADDR if n/z/v/c set, else uaddr+1.
  - 101: JADDR if IR[13], else +1.
  - 110: JADDR always.
  - 111 decode: {1'b1, IR[31:30], IR[24:19], 2'b00}.
  - Increment wraps 2047 → 0. This path is unreachable because HALT_UADDR takes priority.
- Flags and IR are sampled on the advance edge, i.e. the values present in the exec cycle.
- Halt: when the microword at HALT_UADDR executes (exec = 1), go to HALT. halted = 1, exec = 0, uaddr frozen.
- HALT exits: reset, or start low → RUN at RESET_UADDR with halted cleared.
- start asserted during RUN/WAIT_MEM is ignored.
- memAck outside RUN/WAIT_MEM, or on a non-memory microword, is ignored.
- Reset mid-WAIT_MEM drops memReq immediately (asynchronously).

Optional Feature:
- Macro: CC_MIM_SEQUENCER_STEP_EN.
- Defined: adds inputs CC_MIM_Sequencer_stepMode_In and CC_MIM_Sequencer_stepPulse_In.
  - With stepMode = 1, exec and advance in RUN additionally require stepPulse = 1. Otherwise hold with exec = 0.
  - WAIT_MEM still completes on memAck without a pulse.
- Undefined: ports absent; runs freely as above.

Decomposition:
- Package cc_mim_pkg:
  - Field bit-position localparams for the microword.
  - COND encodings (COND_NEXT, COND_N, COND_Z, COND_V, COND_C, COND_IR13, COND_JUMP, COND_DECODE).
  - FSM state typedef.
- Sub-module cc_mim_next_addr: combinational COND/flags/IR → next-address mux. The top holds the FSM and microPC register.

Test Plan:
- Reset, start low 1 cycle, COND=000 microwords → uaddr 0,1,2,3 on consecutive edges, exec = 1 each cycle.
- Microword at 1: COND=111, IR = 0x80800000 (op=10, op3=010000) → next uaddr 1600 (0x640).
- COND=010, JADDR=12: z=1 → 12; repeat with z=0 → uaddr+1. Same check for n, v, c and IR[13].
- Microword RD=1, ack delayed 3 cycles → memReq = 1 and memWr = 0 for 4 cycles, exec = 0 for 3 cycles then 1, uaddr held then advanced. Ack in the first cycle → no stall.
- Reach 2047 → halted = 1 one edge later, uaddr frozen at 2047 for 20 cycles. Start low → uaddr 0, halted = 0.
- Reset asserted asynchronously mid-WAIT_MEM → memReq = 0 and uaddr = 0 before the next clock edge.

Source files
------------

// File: rtl/cc_mim_sequencer_pkg.sv
// Shared definitions for the microprogram sequencer: microword field layout,
// COND encodings and sequencer FSM states.
package cc_mim_pkg;

    localparam int unsigned UW_A_HI     = 40;
    localparam int unsigned UW_A_LO     = 35;
    localparam int unsigned UW_AMUX     = 34;
    localparam int unsigned UW_B_HI     = 33;
    localparam int unsigned UW_B_LO     = 28;
    localparam int unsigned UW_BMUX     = 27;
    localparam int unsigned UW_C_HI     = 26;
    localparam int unsigned UW_C_LO     = 21;
    localparam int unsigned UW_CMUX     = 20;
    localparam int unsigned UW_RD       = 19;
    localparam int unsigned UW_WR       = 18;
    localparam int unsigned UW_ALU_HI   = 17;
    localparam int unsigned UW_ALU_LO   = 14;
    localparam int unsigned UW_COND_HI  = 13;
    localparam int unsigned UW_COND_LO  = 11;
    localparam int unsigned UW_JADDR_HI = 10;
    localparam int unsigned UW_JADDR_LO = 0;

    typedef enum logic [2:0] {
        COND_NEXT   = 3'b000,
        COND_N      = 3'b001,
        COND_Z      = 3'b010,
        COND_V      = 3'b011,
        COND_C      = 3'b100,
        COND_IR13   = 3'b101,
        COND_JUMP   = 3'b110,
        COND_DECODE = 3'b111
    } cond_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        WAIT_MEM = 2'd2,
        HALT     = 2'd3
    } seq_state_e;

endpackage

// File: rtl/cc_mim_sequencer_if.sv
// Sequencer bus: control-store, datapath and memory-handshake signals.
// Optional single-step inputs appear when CC_MIM_SEQUENCER_STEP_EN is defined.
interface cc_mim_sequencer_if #(
    parameter int unsigned DATAWIDTH_UWORD = 41,
    parameter int unsigned DATAWIDTH_UADDR = 11,
    parameter int unsigned DATAWIDTH_IR    = 32
);
    logic                       CC_MIM_Sequencer_start_InLow;
    logic [DATAWIDTH_UWORD-1:0] CC_MIM_Sequencer_uword_InBUS;
    logic [DATAWIDTH_IR-1:0]    CC_MIM_Sequencer_ir_InBUS;
    logic [3:0]                 CC_MIM_Sequencer_flags_InBUS;
    logic                       CC_MIM_Sequencer_memAck_In;
    logic [DATAWIDTH_UADDR-1:0] CC_MIM_Sequencer_uaddr_OutBUS;
    logic                       CC_MIM_Sequencer_exec_Out;
    logic                       CC_MIM_Sequencer_memReq_Out;
    logic                       CC_MIM_Sequencer_memWr_Out;
    logic                       CC_MIM_Sequencer_halted_Out;

`ifdef CC_MIM_SEQUENCER_STEP_EN
    logic CC_MIM_Sequencer_stepMode_In;
    logic CC_MIM_Sequencer_stepPulse_In;

    modport master (
        input  CC_MIM_Sequencer_start_InLow, CC_MIM_Sequencer_uword_InBUS,
               CC_MIM_Sequencer_ir_InBUS, CC_MIM_Sequencer_flags_InBUS,
               CC_MIM_Sequencer_memAck_In,
               CC_MIM_Sequencer_stepMode_In, CC_MIM_Sequencer_stepPulse_In,
        output CC_MIM_Sequencer_uaddr_OutBUS, CC_MIM_Sequencer_exec_Out,
               CC_MIM_Sequencer_memReq_Out, CC_MIM_Sequencer_memWr_Out,
               CC_MIM_Sequencer_halted_Out
    );
    modport slave (
        output CC_MIM_Sequencer_start_InLow, CC_MIM_Sequencer_uword_InBUS,
               CC_MIM_Sequencer_ir_InBUS, CC_MIM_Sequencer_flags_InBUS,
               CC_MIM_Sequencer_memAck_In,
               CC_MIM_Sequencer_stepMode_In, CC_MIM_Sequencer_stepPulse_In,
        input  CC_MIM_Sequencer_uaddr_OutBUS, CC_MIM_Sequencer_exec_Out,
               CC_MIM_Sequencer_memReq_Out, CC_MIM_Sequencer_memWr_Out,
               CC_MIM_Sequencer_halted_Out
    );
`else
    modport master (
        input  CC_MIM_Sequencer_start_InLow, CC_MIM_Sequencer_uword_InBUS,
               CC_MIM_Sequencer_ir_InBUS, CC_MIM_Sequencer_flags_InBUS,
               CC_MIM_Sequencer_memAck_In,
        output CC_MIM_Sequencer_uaddr_OutBUS, CC_MIM_Sequencer_exec_Out,
               CC_MIM_Sequencer_memReq_Out, CC_MIM_Sequencer_memWr_Out,
               CC_MIM_Sequencer_halted_Out
    );
    modport slave (
        output CC_MIM_Sequencer_start_InLow, CC_MIM_Sequencer_uword_InBUS,
               CC_MIM_Sequencer_ir_InBUS, CC_MIM_Sequencer_flags_InBUS,
               CC_MIM_Sequencer_memAck_In,
        input  CC_MIM_Sequencer_uaddr_OutBUS, CC_MIM_Sequencer_exec_Out,
               CC_MIM_Sequencer_memReq_Out, CC_MIM_Sequencer_memWr_Out,
               CC_MIM_Sequencer_halted_Out
    );
`endif

endinterface

// File: rtl/cc_mim_sequencer_next_addr.sv
// Next-microaddress selection: increment, conditional/unconditional jump,
// or opcode decode into the upper half of the control store.
module cc_mim_next_addr
    import cc_mim_pkg::*;
#(
    parameter int unsigned DATAWIDTH_UADDR = 11,
    parameter int unsigned DATAWIDTH_IR    = 32
) (
    input  logic [DATAWIDTH_UADDR-1:0] uaddr,
    input  logic [2:0]                 cond,
    input  logic [DATAWIDTH_UADDR-1:0] jaddr,
    input  logic [3:0]                 flags,
    input  logic [DATAWIDTH_IR-1:0]    ir,
    output logic [DATAWIDTH_UADDR-1:0] next_uaddr
);
    logic                       take_jump;
    logic [DATAWIDTH_UADDR-1:0] incr_uaddr;
    logic [DATAWIDTH_UADDR-1:0] decode_uaddr;
    logic                       unused_ir;

    assign incr_uaddr   = uaddr + DATAWIDTH_UADDR'(1);
    // Decode target: {1, op, op3, 00} gives each op/op3 pair a 4-word slot.
    assign decode_uaddr = DATAWIDTH_UADDR'({1'b1, ir[31:30], ir[24:19], 2'b00});
    assign unused_ir    = ^{ir[29:25], ir[18:14], ir[12:0]};

    always_comb begin
        take_jump = 1'b0;
        case (cond)
            COND_N:    take_jump = flags[3];
            COND_Z:    take_jump = flags[2];
            COND_V:    take_jump = flags[1];
            COND_C:    take_jump = flags[0];
            COND_IR13: take_jump = ir[13];
            COND_JUMP: take_jump = 1'b1;
            default:   take_jump = 1'b0;
        endcase
    end

    always_comb begin
        next_uaddr = incr_uaddr;
        if (cond == COND_DECODE) begin
            next_uaddr = decode_uaddr;
        end else if (take_jump) begin
            next_uaddr = jaddr;
        end
    end

endmodule

// File: rtl/cc_mim_sequencer.sv
// Microprogram sequencer: FSM, microPC register and memory-stall handling.
// Define CC_MIM_SEQUENCER_STEP_EN to add single-step gating of the RUN state.
module cc_mim_sequencer
    import cc_mim_pkg::*;
#(
    parameter int unsigned DATAWIDTH_UWORD = 41,
    parameter int unsigned DATAWIDTH_UADDR = 11,
    parameter int unsigned DATAWIDTH_IR    = 32,
    parameter int unsigned RESET_UADDR     = 0,
    parameter int unsigned HALT_UADDR      = 2047
) (
    input  logic              CC_MIM_Sequencer_CLOCK_50,
    input  logic              CC_MIM_Sequencer_RESET_InLow,
    cc_mim_sequencer_if.master bus
);
    seq_state_e                 state_q, state_next;
    logic [DATAWIDTH_UADDR-1:0] uaddr_q, uaddr_next, adv_uaddr;
    logic [DATAWIDTH_UWORD-1:0] uword;
    logic                       mem_op, run_ok;
    logic                       exec, mem_req, mem_wr;
    logic                       unused_fields;

    assign uword         = bus.CC_MIM_Sequencer_uword_InBUS;
    assign mem_op        = uword[UW_RD] | uword[UW_WR];
    assign unused_fields = ^uword[UW_A_HI:UW_CMUX];

`ifdef CC_MIM_SEQUENCER_STEP_EN
    assign run_ok = ~bus.CC_MIM_Sequencer_stepMode_In | bus.CC_MIM_Sequencer_stepPulse_In;
`else
    assign run_ok = 1'b1;
`endif

    cc_mim_next_addr #(
        .DATAWIDTH_UADDR (DATAWIDTH_UADDR),
        .DATAWIDTH_IR    (DATAWIDTH_IR)
    ) u_next_addr (
        .uaddr      (uaddr_q),
        .cond       (uword[UW_COND_HI:UW_COND_LO]),
        .jaddr      (DATAWIDTH_UADDR'(uword[UW_JADDR_HI:UW_JADDR_LO])),
        .flags      (bus.CC_MIM_Sequencer_flags_InBUS),
        .ir         (bus.CC_MIM_Sequencer_ir_InBUS),
        .next_uaddr (adv_uaddr)
    );

    always_ff @(posedge CC_MIM_Sequencer_CLOCK_50 or negedge CC_MIM_Sequencer_RESET_InLow) begin
        if (!CC_MIM_Sequencer_RESET_InLow) begin
            state_q <= IDLE;
            uaddr_q <= DATAWIDTH_UADDR'(RESET_UADDR);
        end else begin
            state_q <= state_next;
            uaddr_q <= uaddr_next;
        end
    end

    always_comb begin
        state_next = state_q;
        uaddr_next = uaddr_q;
        exec       = 1'b0;
        mem_req    = 1'b0;
        mem_wr     = 1'b0;
        case (state_q)
            IDLE, HALT: begin
                if (!bus.CC_MIM_Sequencer_start_InLow) begin
                    state_next = RUN;
                    uaddr_next = DATAWIDTH_UADDR'(RESET_UADDR);
                end
            end
            RUN: begin
                if (run_ok) begin
                    if (mem_op) begin
                        mem_req = 1'b1;
                        mem_wr  = uword[UW_WR];
                        if (bus.CC_MIM_Sequencer_memAck_In) begin
                            exec = 1'b1;
                        end else begin
                            state_next = WAIT_MEM;
                        end
                    end else begin
                        exec = 1'b1;
                    end
                end
            end
            WAIT_MEM: begin
                mem_req = 1'b1;
                mem_wr  = uword[UW_WR];
                if (bus.CC_MIM_Sequencer_memAck_In) begin
                    exec       = 1'b1;
                    state_next = RUN;
                end
            end
            default: state_next = IDLE;
        endcase
        // Executing the halt word overrides any advance, freezing the microPC.
        if (exec) begin
            if (uaddr_q == DATAWIDTH_UADDR'(HALT_UADDR)) begin
                state_next = HALT;
            end else begin
                uaddr_next = adv_uaddr;
            end
        end
    end

    assign bus.CC_MIM_Sequencer_uaddr_OutBUS = uaddr_q;
    assign bus.CC_MIM_Sequencer_exec_Out     = exec;
    assign bus.CC_MIM_Sequencer_memReq_Out   = mem_req;
    assign bus.CC_MIM_Sequencer_memWr_Out    = mem_wr;
    assign bus.CC_MIM_Sequencer_halted_Out   = (state_q == HALT);

endmodule

// File: tb/tb_cc_mim_sequencer.sv
// Self-checking bench for cc_mim_sequencer: a cycle-level model checked every
// cycle plus directed scenarios with literal expectations.
module tb_cc_mim_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start_n = 1'b1;
    logic        ack = 1'b0;
    logic [3:0]  flags = 4'h0;
    logic [31:0] ir = 32'h0;
    logic [40:0] rom [2048];

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: microPC, whether a program is running, whether halted.
    logic [10:0] m_uaddr = 11'd0;
    bit          m_active = 1'b0;
    bit          m_halted = 1'b0;
    logic [10:0] n_uaddr = 11'd0;
    bit          n_active = 1'b0;
    bit          n_halted = 1'b0;
    logic [40:0] c_w;
    bit          e_exec, e_req, e_wr;

    always #5 clk = ~clk;

    cc_mim_sequencer_if #(
        .DATAWIDTH_UWORD (41),
        .DATAWIDTH_UADDR (11),
        .DATAWIDTH_IR    (32)
    ) bus ();

    assign bus.CC_MIM_Sequencer_start_InLow = start_n;
    assign bus.CC_MIM_Sequencer_uword_InBUS = rom[bus.CC_MIM_Sequencer_uaddr_OutBUS];
    assign bus.CC_MIM_Sequencer_ir_InBUS    = ir;
    assign bus.CC_MIM_Sequencer_flags_InBUS = flags;
    assign bus.CC_MIM_Sequencer_memAck_In   = ack;

    cc_mim_sequencer #(
        .DATAWIDTH_UWORD (41),
        .DATAWIDTH_UADDR (11),
        .DATAWIDTH_IR    (32),
        .RESET_UADDR     (0),
        .HALT_UADDR      (2047)
    ) dut (
        .CC_MIM_Sequencer_CLOCK_50    (clk),
        .CC_MIM_Sequencer_RESET_InLow (rst_n),
        .bus                          (bus)
    );

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [10:0] model_next(input logic [10:0] ua, input logic [40:0] w,
                                               input logic [3:0] f, input logic [31:0] iv);
        int unsigned cond, op, op3;
        bit take;
        cond = int'(w[13:11]);
        take = 1'b0;
        case (cond)
            1: take = f[3];
            2: take = f[2];
            3: take = f[1];
            4: take = f[0];
            5: take = iv[13];
            6: take = 1'b1;
            7: begin
                op  = int'(iv[31:30]);
                op3 = int'(iv[24:19]);
                return 11'(1024 + op * 256 + op3 * 4);
            end
            default: take = 1'b0;
        endcase
        if (take) return w[10:0];
        return 11'((int'(ua) + 1) % 2048);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_uaddr  <= 11'd0;
            m_active <= 1'b0;
            m_halted <= 1'b0;
        end else begin
            m_uaddr  <= n_uaddr;
            m_active <= n_active;
            m_halted <= n_halted;
        end
    end

    // Compare on the falling edge, then compute the model's next state.
    always @(negedge clk) begin
        c_w    = rom[m_uaddr];
        e_exec = 1'b0;
        e_req  = 1'b0;
        e_wr   = 1'b0;
        if (rst_n && m_active) begin
            if (c_w[19] || c_w[18]) begin
                e_req  = 1'b1;
                e_wr   = c_w[18];
                e_exec = ack;
            end else begin
                e_exec = 1'b1;
            end
        end
        check("m_uaddr", bus.CC_MIM_Sequencer_uaddr_OutBUS, m_uaddr);
        check("m_exec", bus.CC_MIM_Sequencer_exec_Out, e_exec);
        check("m_memReq", bus.CC_MIM_Sequencer_memReq_Out, e_req);
        check("m_halted", bus.CC_MIM_Sequencer_halted_Out, m_halted);
        if (e_req) check("m_memWr", bus.CC_MIM_Sequencer_memWr_Out, e_wr);
        n_uaddr  = m_uaddr;
        n_active = m_active;
        n_halted = m_halted;
        if (e_exec) begin
            if (m_uaddr == 11'd2047) begin
                n_active = 1'b0;
                n_halted = 1'b1;
            end else begin
                n_uaddr = model_next(m_uaddr, c_w, flags, ir);
            end
        end else if (rst_n && !m_active && !start_n) begin
            n_active = 1'b1;
            n_halted = 1'b0;
            n_uaddr  = 11'd0;
        end
    end

    task automatic step_cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut;
        rst_n   = 1'b0;
        start_n = 1'b1;
        ack     = 1'b0;
        flags   = 4'h0;
        ir      = 32'h0;
        for (int i = 0; i < 2048; i++) rom[i] = '0;
        step_cyc();
        rst_n = 1'b1;
    endtask

    // Leaves the bench 2 time units after the edge that entered RUN at uaddr 0.
    task automatic start_run;
        start_n = 1'b0;
        step_cyc();
        start_n = 1'b1;
        #1;
    endtask

    logic [3:0] bitsel;

    initial begin
        for (int i = 0; i < 2048; i++) rom[i] = '0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_uaddr", bus.CC_MIM_Sequencer_uaddr_OutBUS, 0);
        check("rst_exec", bus.CC_MIM_Sequencer_exec_Out, 0);
        check("rst_memReq", bus.CC_MIM_Sequencer_memReq_Out, 0);
        check("rst_halted", bus.CC_MIM_Sequencer_halted_Out, 0);
        reset_dut();

        // Ack while idle is ignored.
        ack = 1'b1;
        step_cyc();
        ack = 1'b0;
        #1;
        check("idle_uaddr", bus.CC_MIM_Sequencer_uaddr_OutBUS, 0);
        check("idle_exec", bus.CC_MIM_Sequencer_exec_Out, 0);

        // Sequential microwords.
        reset_dut();
        start_run();
        for (int k = 0; k < 4; k++) begin
            check("seq_uaddr", bus.CC_MIM_Sequencer_uaddr_OutBUS, k);
            check("seq_exec", bus.CC_MIM_Sequencer_exec_Out, 1);
            step_cyc();
            #1;
        end

        // Decode: op=10, op3=010000 -> 1600.
        reset_dut();
        rom[1] = {27'd0, 3'b111, 11'd0};
        ir = 32'h8080_0000;
        start_run();
        step_cyc();
        step_cyc();
        check("decode", bus.CC_MIM_Sequencer_uaddr_OutBUS, 1600);

        // Conditional jumps on n/z/v/c/IR[13], taken and not taken.
        for (int c = 1; c <= 5; c++) begin
            for (int t = 0; t < 2; t++) begin
                reset_dut();
                rom[0] = {27'd0, 3'(c), 11'd12};
                bitsel = 4'b1000 >> (c - 1);
                flags  = (t == 1) ? bitsel : ~bitsel;
                ir     = (t == 1) ? 32'h0000_2000 : ~32'h0000_2000;
                start_run();
                step_cyc();
                check("cond_jump", bus.CC_MIM_Sequencer_uaddr_OutBUS, (t == 1) ? 12 : 1);
            end
        end
        reset_dut();
        rom[0] = {27'd0, 3'b110, 11'd12};
        start_run();
        step_cyc();
        check("uncond_jump", bus.CC_MIM_Sequencer_uaddr_OutBUS, 12);

        // Read at uaddr 2 acked in its 4th cycle; RD+WR at 3 acked at once.
        reset_dut();
        rom[2] = 41'd1 << 19;
        rom[3] = 41'd3 << 18;
        start_run();
        step_cyc();
        step_cyc();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) ack = 1'b1;
            #1;
            check("rd_memReq", bus.CC_MIM_Sequencer_memReq_Out, 1);
            check("rd_memWr", bus.CC_MIM_Sequencer_memWr_Out, 0);
            check("rd_uaddr", bus.CC_MIM_Sequencer_uaddr_OutBUS, 2);
            check("rd_exec", bus.CC_MIM_Sequencer_exec_Out, (i == 3) ? 1 : 0);
            step_cyc();
        end
        #1;
        check("wr_uaddr", bus.CC_MIM_Sequencer_uaddr_OutBUS, 3);
        check("wr_exec", bus.CC_MIM_Sequencer_exec_Out, 1);
        check("wr_memWr", bus.CC_MIM_Sequencer_memWr_Out, 1);
        step_cyc();
        ack = 1'b0;
        #1;
        check("wr_adv", bus.CC_MIM_Sequencer_uaddr_OutBUS, 4);

        // Halt at 2047, then restart.
        reset_dut();
        rom[0] = {27'd0, 3'b110, 11'd2046};
        start_run();
        step_cyc();
        step_cyc();
        check("pre_halt_uaddr", bus.CC_MIM_Sequencer_uaddr_OutBUS, 2047);
        check("pre_halt_exec", bus.CC_MIM_Sequencer_exec_Out, 1);
        check("pre_halt_halted", bus.CC_MIM_Sequencer_halted_Out, 0);
        step_cyc();
        check("halt_halted", bus.CC_MIM_Sequencer_halted_Out, 1);
        check("halt_exec", bus.CC_MIM_Sequencer_exec_Out, 0);
        for (int i = 0; i < 20; i++) step_cyc();
        check("halt_frozen", bus.CC_MIM_Sequencer_uaddr_OutBUS, 2047);
        start_n = 1'b0;
        step_cyc();
        start_n = 1'b1;
        #1;
        check("restart_uaddr", bus.CC_MIM_Sequencer_uaddr_OutBUS, 0);
        check("restart_halted", bus.CC_MIM_Sequencer_halted_Out, 0);

        // Asynchronous reset while waiting on memory.
        reset_dut();
        rom[0] = {27'd0, 3'b110, 11'd5};
        rom[5] = 41'd1 << 19;
        start_run();
        step_cyc();
        check("wait_memReq", bus.CC_MIM_Sequencer_memReq_Out, 1);
        step_cyc();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_memReq", bus.CC_MIM_Sequencer_memReq_Out, 0);
        check("async_uaddr", bus.CC_MIM_Sequencer_uaddr_OutBUS, 0);
        step_cyc();
        rst_n = 1'b1;
        step_cyc();
        step_cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
